// File: rtl/prog_counter_pkg.sv
// Shared constants and helpers for prog_counter and its prescaler.
package prog_counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Limits a value to the modulus top; callers widen to 32 bits first.
    function automatic logic [31:0] clamp_max(input logic [31:0] val,
                                              input logic [31:0] max_val);
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/prog_counter_prescaler.sv
// Clock-enable divider: tick is high one enabled cycle in every presc_div+1.
module prog_counter_prescaler
    import prog_counter_pkg::*;
#(
    parameter int unsigned PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] presc_div,
    output logic               tick
);

    logic [PRESC_W-1:0] div;

    assign tick = (div == presc_div);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            div <= '0;
        end else if (en) begin
            div <= tick ? '0 : div + 1'b1;
        end
    end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with modulus, load, wrap/saturate and flags.
// Optional prescaler compiled in with `define PROG_COUNTER_PRESCALER_EN.
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = '1,
    parameter int unsigned      PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               up_dn,
    input  logic               sat_mode,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic [WIDTH-1:0]   cmp_val,
    input  logic [PRESC_W-1:0] presc_div,
    input  logic               ovf_clr,
    output logic [WIDTH-1:0]   count,
    output logic               tc,
    output logic               ovf_sticky,
    output logic               cmp_hit
);

    logic             tick;
    logic [WIDTH-1:0] count_next;
    logic             tc_next;
    logic             ovf_next;

`ifdef PROG_COUNTER_PRESCALER_EN
    prog_counter_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr       (load),
        .presc_div (presc_div),
        .tick      (tick)
    );
`else
    logic unused_presc;
    assign tick         = 1'b1;
    assign unused_presc = ^presc_div;
`endif

    always_comb begin
        count_next = count;
        tc_next    = 1'b0;
        if (load) begin
            count_next = WIDTH'(clamp_max(32'(load_val), 32'(MAX_VAL)));
        end else if (en && tick) begin
            case (up_dn)
                DIR_UP: begin
                    if (count < MAX_VAL) begin
                        count_next = count + 1'b1;
                    end else begin
                        tc_next    = 1'b1;
                        count_next = (sat_mode == MODE_SAT) ? MAX_VAL : '0;
                    end
                end
                DIR_DOWN: begin
                    if (count != '0) begin
                        count_next = count - 1'b1;
                    end else begin
                        tc_next    = 1'b1;
                        count_next = (sat_mode == MODE_WRAP) ? MAX_VAL : '0;
                    end
                end
                default: count_next = count;
            endcase
        end
        // A boundary event on the same edge as a clear keeps the flag set.
        ovf_next = tc_next | (ovf_sticky & ~ovf_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            tc         <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            count      <= count_next;
            tc         <= tc_next;
            ovf_sticky <= ovf_next;
        end
    end

    assign cmp_hit = (count == cmp_val);

endmodule

// File: doc/prog_counter.md
# prog_counter

Parametrised, programmable up/down counter replacing the fixed 8-bit enable counter. It adds configurable width and modulus, direction control, parallel load, wrap or saturate mode, a terminal-count pulse, a sticky overflow flag and a compare-match output. It sits wherever the design needs event counting, timeouts or periodic ticks. An optional clock-enable prescaler can be compiled in.

## Interface
Parameters:
- WIDTH, 8, counter width in bits (2..32)
- MAX_VAL, 2**WIDTH-1, modulus top value; the count range is 0..MAX_VAL
- PRESC_W, 4, prescaler divider width (used only with the prescaler compiled in)

Ports:
- clk  in  1  clock, all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  count enable
- up_dn  in  1  direction: 1 = up, 0 = down
- sat_mode  in  1  boundary mode: 1 = saturate, 0 = wrap
- load  in  1  parallel load strobe
- load_val  in  WIDTH  value to load
- cmp_val  in  WIDTH  compare value
- presc_div  in  PRESC_W  prescaler terminal value; one step per presc_div+1 enabled cycles
- ovf_clr  in  1  clears ovf_sticky
- count  out  WIDTH  current count (registered)
- tc  out  1  terminal-count pulse (registered, one cycle)
- ovf_sticky  out  1  sticky boundary-event flag
- cmp_hit  out  1  count == cmp_val

## Operation
- Priority per edge: rst, then load, then step.
- rst: count=0, tc=0, ovf_sticky=0, prescaler divider=0.
- load: count = min(load_val, MAX_VAL). Load clears tc for that cycle and resets the prescaler divider to 0. The step is suppressed.
- Step condition: en && tick. Without the prescaler, tick=1.
- Up step:
  - count<MAX_VAL: count+1.
  - count==MAX_VAL: wrap mode gives 0; saturate mode holds MAX_VAL.
  - tc=1 in both cases.
- Down step:
  - count>0: count-1.
  - count==0: wrap mode gives MAX_VAL; saturate mode holds 0.
  - tc=1 in both cases.
- tc is 0 in every other cycle. In saturate mode, each step attempted at the boundary pulses tc again.
- ovf_sticky is set on any cycle where tc is set and holds until ovf_clr. If set and clear occur on the same edge, set wins.
- en=0: count, tc=0 and the divider all hold.
- Direction or mode changes take effect on the next step; they carry no state.
- Arithmetic is done in WIDTH bits. When MAX_VAL < 2**WIDTH-1, wrap happens at MAX_VAL, not at the natural width.
- cmp_hit is a combinational compare of the registered count. It is valid in the same cycle count changes.

## Timing
- count and tc update on the edge after en/load are sampled: 1-cycle latency.
- ovf_sticky rises on the same edge as tc.
- cmp_hit has 0-cycle latency from count.
- Reset mid-count or mid-prescale takes effect on the next edge. All outputs read 0 the following cycle, except cmp_hit, which equals (cmp_val==0).
- load while en=1 loads. The first step from the loaded value occurs on the next qualifying cycle.

## Configuration
- PROG_COUNTER_PRESCALER_EN defined:
  - An internal PRESC_W-bit divider runs while en=1.
  - tick=1 when the divider equals presc_div. The divider then returns to 0; otherwise it increments.
  - presc_div=0 gives one step per enabled cycle.
- PROG_COUNTER_PRESCALER_EN undefined:
  - tick tied to 1 and no divider logic exists.
  - presc_div is ignored; PRESC_W is still accepted.

## Structure
- Shared package prog_counter_pkg holds:
  - localparams DIR_UP=1'b1 and DIR_DOWN=1'b0.
  - localparams MODE_WRAP=1'b0 and MODE_SAT=1'b1.
  - a helper function for clamping against MAX_VAL.
- One sub-module, prog_counter_prescaler, holds the divider and the tick output. It is instantiated only under PROG_COUNTER_PRESCALER_EN.

## Test plan
- Reset then up count: rst 1 cycle, en=1, up_dn=1, WIDTH=8 → count 0,1,2…255,0. tc=1 only in the cycle count shows 0 after 255. ovf_sticky=1 afterwards.
- Saturate down: load_val=2, sat_mode=1, up_dn=0, en=1 → count 2,1,0,0,0. tc=1 on each cycle at 0 after the first arrival at 0.
- Modulus wrap: MAX_VAL=9, up → 8,9,0. Then load_val=200 → count=9 (clamp). Down from 0 → 9.
- Priority: load=1 with en=1, load_val=0x40 → count=0x40, no step, tc=0. Then rst=1 with load=1 → count=0. Then ovf_sticky set and ovf_clr on the same edge → ovf_sticky stays 1.
- Compare: cmp_val=5, up from 0 → cmp_hit=1 exactly while count==5.
- Prescaler (macro defined): presc_div=3, en=1 → count steps every 4 cycles. Drop en for 2 cycles mid-prescale → the divider holds and the step is delayed by exactly 2 cycles.
